// File: rtl/net_sweep_controller_if.sv
// Signal bundle between the sweep controller and its host / net under test.
// The controller owns abcd and the status outputs; the host owns start, abort and xy.
interface net_sweep_controller_if;
    logic       start;
    logic       abort;
    logic [1:0] xy;
    logic [3:0] abcd;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] error_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_index;

    modport master (
        output start, abort, xy,
        input  abcd, busy, done, pass, error_count, first_fail_valid, first_fail_index
    );

    modport slave (
        input  start, abort, xy,
        output abcd, busy, done, pass, error_count, first_fail_valid, first_fail_index
    );
endinterface

// File: rtl/net_sweep_controller.sv
// Drives abcd through 0..15, holds each value HOLD_CYCLES cycles, and checks xy
// against the EXPECTED truth table on the last hold cycle of each combination.
module net_sweep_controller #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [31:0] EXPECTED    = 32'h0
) (
    input  logic                   clock,
    input  logic                   reset,
    net_sweep_controller_if.slave  sweep
);
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ERR_W  = 5;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(15);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state,  w_state_next;
    logic [IDX_W-1:0]   r_index,  w_index_next;
    logic [HOLD_W-1:0]  r_hold,   w_hold_next;
    logic [IDX_W-1:0]   r_abcd,   w_abcd_next;
    logic               r_busy,   w_busy_next;
    logic               r_done,   w_done_next;
    logic               r_pass,   w_pass_next;
    logic [ERR_W-1:0]   r_err,    w_err_next;
    logic               r_ffv,    w_ffv_next;
    logic [IDX_W-1:0]   r_ffi,    w_ffi_next;
    logic [1:0]         w_exp_xy;
    logic               w_mismatch;

    assign w_exp_xy   = EXPECTED[{r_index, 1'b0} +: 2];
    assign w_mismatch = (sweep.xy != w_exp_xy);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_hold  <= '0;
            r_abcd  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffi   <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_hold  <= w_hold_next;
            r_abcd  <= w_abcd_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_pass  <= w_pass_next;
            r_err   <= w_err_next;
            r_ffv   <= w_ffv_next;
            r_ffi   <= w_ffi_next;
        end
    end

    // Next-state and next-output logic; every registered output is computed one cycle ahead.
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_hold_next  = r_hold;
        w_abcd_next  = '0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        w_pass_next  = r_pass;
        w_err_next   = r_err;
        w_ffv_next   = r_ffv;
        w_ffi_next   = r_ffi;

        unique case (r_state)
            S_IDLE: begin
                if (sweep.start) begin
                    w_state_next = S_RUN;
                    w_index_next = '0;
                    w_hold_next  = '0;
                    w_busy_next  = 1'b1;
                    w_pass_next  = 1'b0;
                    w_err_next   = '0;
                    w_ffv_next   = 1'b0;
                    w_ffi_next   = '0;
                end
            end
            S_RUN: begin
                if (sweep.abort) begin
                    // Abort beats a coincident compare: partial results stay, nothing accumulates.
                    w_state_next = S_IDLE;
                    w_index_next = '0;
                    w_hold_next  = '0;
                end else if (r_hold == HOLD_LAST) begin
                    if (w_mismatch) begin
                        w_err_next = r_err + ERR_W'(1);
                        if (!r_ffv) begin
                            w_ffv_next = 1'b1;
                            w_ffi_next = r_index;
                        end
                    end
                    w_hold_next  = '0;
                    w_index_next = r_index + IDX_W'(1);
                    if (r_index == IDX_LAST) begin
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                        w_pass_next  = (w_err_next == '0);
                    end else begin
                        w_busy_next = 1'b1;
                        w_abcd_next = r_index + IDX_W'(1);
                    end
                end else begin
                    w_hold_next = r_hold + HOLD_W'(1);
                    w_busy_next = 1'b1;
                    w_abcd_next = r_index;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign sweep.abcd             = r_abcd;
    assign sweep.busy             = r_busy;
    assign sweep.done             = r_done;
    assign sweep.pass             = r_pass;
    assign sweep.error_count      = r_err;
    assign sweep.first_fail_valid = r_ffv;
    assign sweep.first_fail_index = r_ffi;
endmodule

// File: tb/tb_net_sweep_controller.sv
// Directed bench for net_sweep_controller with HOLD_CYCLES = 4 and xy = abcd[1:0] as the good net.
module tb_net_sweep_controller;
    localparam int unsigned HOLD = 4;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    net_sweep_controller_if u_if ();

    net_sweep_controller #(
        .HOLD_CYCLES (HOLD),
        .EXPECTED    (32'hE4E4E4E4)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .sweep (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Net model: 0 good, 1 drops xy at abcd 5 and 10, 2 stuck at 00, 3 wrong except on the sample cycle.
    function automatic logic [1:0] model_xy(input int mode, input logic [3:0] idx, input int phase);
        logic [1:0] good;
        good = idx[1:0];
        case (mode)
            1:       return (idx == 4'd5 || idx == 4'd10) ? 2'b00 : good;
            2:       return 2'b00;
            3:       return (phase == int'(HOLD) - 1) ? good : ~good;
            default: return good;
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        u_if.start = 1'b1;
        u_if.abort = 1'b0;
        u_if.xy = 2'b00;
        @(posedge clock); @(posedge clock); #1;
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", u_if.busy); end
        checks++; if (u_if.abcd !== 4'd0) begin errors++; $display("FAIL reset_abcd got %0d exp 0", u_if.abcd); end
        checks++; if (u_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", u_if.done); end
        checks++; if (u_if.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %0b exp 0", u_if.pass); end
        checks++; if (u_if.error_count !== 5'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", u_if.error_count); end
        checks++; if (u_if.first_fail_valid !== 1'b0 || u_if.first_fail_index !== 4'd0) begin
            errors++; $display("FAIL reset_ff got %0b/%0d exp 0/0", u_if.first_fail_valid, u_if.first_fail_index); end
        u_if.start = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", u_if.busy); end
    endtask

    // Full sweep from IDLE; checks stimulus each cycle and results at/after done.
    task automatic do_sweep(input string name, input int mode, input bit hold_start, input int exp_err,
                            input bit exp_ffv, input int exp_ffi, input bit exp_pass);
        logic [3:0] idx;
        u_if.start = 1'b1;
        @(posedge clock); #1;
        if (!hold_start) u_if.start = 1'b0;
        checks++; if (u_if.error_count !== 5'd0 || u_if.first_fail_valid !== 1'b0 || u_if.pass !== 1'b0) begin
            errors++; $display("FAIL %s_cleared got err %0d ffv %0b pass %0b exp 0/0/0", name,
                               u_if.error_count, u_if.first_fail_valid, u_if.pass); end
        for (int k = 0; k < 16 * int'(HOLD); k++) begin
            idx = 4'(k / int'(HOLD));
            checks++; if (u_if.abcd !== idx || u_if.busy !== 1'b1 || u_if.done !== 1'b0) begin
                errors++; $display("FAIL %s_run k=%0d got abcd %0d busy %0b done %0b exp %0d/1/0", name, k,
                                   u_if.abcd, u_if.busy, u_if.done, idx); end
            u_if.xy = model_xy(mode, idx, k % int'(HOLD));
            @(posedge clock); #1;
        end
        checks++; if (u_if.done !== 1'b1 || u_if.busy !== 1'b0 || u_if.abcd !== 4'd0) begin
            errors++; $display("FAIL %s_done got done %0b busy %0b abcd %0d exp 1/0/0", name,
                               u_if.done, u_if.busy, u_if.abcd); end
        checks++; if (u_if.pass !== exp_pass) begin errors++; $display("FAIL %s_pass got %0b exp %0b", name, u_if.pass, exp_pass); end
        checks++; if (u_if.error_count !== 5'(exp_err)) begin
            errors++; $display("FAIL %s_err got %0d exp %0d", name, u_if.error_count, exp_err); end
        checks++; if (u_if.first_fail_valid !== exp_ffv || u_if.first_fail_index !== 4'(exp_ffi)) begin
            errors++; $display("FAIL %s_ff got %0b/%0d exp %0b/%0d", name, u_if.first_fail_valid,
                               u_if.first_fail_index, exp_ffv, exp_ffi); end
        @(posedge clock); #1;
        checks++; if (u_if.done !== 1'b0 || u_if.busy !== 1'b0 || u_if.pass !== exp_pass || u_if.error_count !== 5'(exp_err)) begin
            errors++; $display("FAIL %s_after got done %0b busy %0b pass %0b err %0d exp 0/0/%0b/%0d", name,
                               u_if.done, u_if.busy, u_if.pass, u_if.error_count, exp_pass, exp_err); end
        if (hold_start) begin
            @(posedge clock); #1;
            checks++; if (u_if.busy !== 1'b1 || u_if.abcd !== 4'd0 || u_if.error_count !== 5'd0) begin
                errors++; $display("FAIL %s_restart got busy %0b abcd %0d err %0d exp 1/0/0", name,
                                   u_if.busy, u_if.abcd, u_if.error_count); end
            u_if.start = 1'b0;
            u_if.abort = 1'b1;
            @(posedge clock); #1;
            u_if.abort = 1'b0;
            checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL %s_abort got busy %0b exp 0", name, u_if.busy); end
        end
    endtask

    task automatic test_abort;
        logic [3:0] idx;
        u_if.start = 1'b1;
        @(posedge clock); #1;
        u_if.start = 1'b0;
        for (int k = 0; k < 7 * int'(HOLD); k++) begin
            idx = 4'(k / int'(HOLD));
            checks++; if (u_if.abcd !== idx || u_if.busy !== 1'b1) begin
                errors++; $display("FAIL abort_run k=%0d got abcd %0d busy %0b exp %0d/1", k, u_if.abcd, u_if.busy, idx); end
            u_if.start = (k == 8 || k == 9);
            u_if.xy = model_xy(2, idx, k % int'(HOLD));
            @(posedge clock); #1;
        end
        checks++; if (u_if.abcd !== 4'd7) begin errors++; $display("FAIL abort_at7 got %0d exp 7", u_if.abcd); end
        u_if.abort = 1'b1;
        @(posedge clock); #1;
        u_if.abort = 1'b0;
        checks++; if (u_if.busy !== 1'b0 || u_if.abcd !== 4'd0 || u_if.done !== 1'b0 || u_if.pass !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy %0b abcd %0d done %0b pass %0b exp 0/0/0/0",
                               u_if.busy, u_if.abcd, u_if.done, u_if.pass); end
        checks++; if (u_if.error_count !== 5'd5 || u_if.first_fail_valid !== 1'b1 || u_if.first_fail_index !== 4'd1) begin
            errors++; $display("FAIL abort_partial got err %0d ffv %0b ffi %0d exp 5/1/1",
                               u_if.error_count, u_if.first_fail_valid, u_if.first_fail_index); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            checks++; if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
                errors++; $display("FAIL abort_quiet got done %0b busy %0b exp 0/0", u_if.done, u_if.busy); end
        end
        do_sweep("after_abort", 0, 1'b0, 0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [3:0] idx;
        u_if.start = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < 9 * int'(HOLD); k++) begin
            idx = 4'(k / int'(HOLD));
            u_if.xy = model_xy(2, idx, k % int'(HOLD));
            @(posedge clock); #1;
        end
        checks++; if (u_if.abcd !== 4'd9 || u_if.error_count !== 5'd6) begin
            errors++; $display("FAIL rstmid_pre got abcd %0d err %0d exp 9/6", u_if.abcd, u_if.error_count); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (u_if.busy !== 1'b0 || u_if.abcd !== 4'd0 || u_if.done !== 1'b0 || u_if.pass !== 1'b0 ||
                      u_if.error_count !== 5'd0 || u_if.first_fail_valid !== 1'b0 || u_if.first_fail_index !== 4'd0) begin
            errors++; $display("FAIL rstmid_vals got busy %0b abcd %0d done %0b pass %0b err %0d ffv %0b ffi %0d exp all 0",
                               u_if.busy, u_if.abcd, u_if.done, u_if.pass, u_if.error_count,
                               u_if.first_fail_valid, u_if.first_fail_index); end
        reset = 1'b0;
        @(posedge clock); #1;
        checks++; if (u_if.busy !== 1'b1 || u_if.abcd !== 4'd0) begin
            errors++; $display("FAIL rstmid_restart got busy %0b abcd %0d exp 1/0", u_if.busy, u_if.abcd); end
        u_if.start = 1'b0;
        u_if.abort = 1'b1;
        @(posedge clock); #1;
        u_if.abort = 1'b0;
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_abort got busy %0b exp 0", u_if.busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        do_sweep("clean", 0, 1'b0, 0, 1'b0, 0, 1'b1);
        do_sweep("drop5_10", 1, 1'b0, 2, 1'b1, 5, 1'b0);
        do_sweep("stuck00", 2, 1'b0, 12, 1'b1, 1, 1'b0);
        do_sweep("sample_pt", 3, 1'b0, 0, 1'b0, 0, 1'b1);
        test_abort();
        do_sweep("back_to_back", 0, 1'b1, 0, 1'b0, 0, 1'b1);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
